// File: rtl/mem_port_if.sv
// rtl/mem_port_if.sv - external memory req/ack bus between mem_port and the memory
interface mem_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;

  // mem_port drives the request side
  modport master (
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata
  );

  // the memory answers with ack/rdata
  modport slave (
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata
  );
endinterface

// File: rtl/mem_port.sv
// rtl/mem_port.sv - memory access unit: control commands to req/ack access, owns ir/mdr (option: MEM_TIMEOUT_EN)
module mem_port #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              i_or_d,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_err,
  mem_port_if.master        ext
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_cmd;
  logic              w_start;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_to_ir;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;

  assign w_cmd   = ir_write | mem_read | mem_write;
  assign w_start = (r_state == S_IDLE) && w_cmd;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;

  // counts REQ cycles that passed without an ack; the final one trips the timeout
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // wait counter: cleared when an access is launched, bumped per un-acked REQ cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ && !ext.ext_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mem_err = (r_state == S_ERR);
`else
  assign mem_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and stall; stall rises in the IDLE cycle a command appears
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd) begin
          stall  = 1'b1;
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (ext.ext_ack) begin
          w_next = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (w_timeout) begin
          w_next = S_ERR;
        end
`endif
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      S_ERR: begin
        stall = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // launch latches the access (write beats fetch beats load); read ack fills ir or mdr
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_to_ir <= 1'b0;
      r_ir    <= '0;
      r_mdr   <= '0;
    end else begin
      if (w_start) begin
        r_addr  <= i_or_d ? alu_out : pc;
        r_wdata <= wr_data;
        r_we    <= mem_write;
        r_to_ir <= !mem_write && ir_write;
      end
      if (r_state == S_REQ && ext.ext_ack && !r_we) begin
        if (r_to_ir) begin
          r_ir <= ext.ext_rdata;
        end else begin
          r_mdr <= ext.ext_rdata;
        end
      end
    end
  end

  assign ext.ext_req   = (r_state == S_REQ);
  assign ext.ext_we    = r_we;
  assign ext.ext_addr  = r_addr;
  assign ext.ext_wdata = r_wdata;
  assign ir            = r_ir;
  assign mdr           = r_mdr;

endmodule

// File: tb/tb_mem_port.sv
// tb/tb_mem_port.sv - randomized self-checking bench for mem_port against a transaction-level model
module tb_mem_port;

`ifdef MEM_TIMEOUT_EN
  localparam int MAX_LAT = 4;
`else
  localparam int MAX_LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ir_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        i_or_d = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] wr_data = '0;
  logic        stall;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_ir  = '0;
  logic [31:0] m_mdr = '0;

  mem_port_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_port #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .i_or_d    (i_or_d),
    .pc        (pc),
    .alu_out   (alu_out),
    .wr_data   (wr_data),
    .stall     (stall),
    .ir        (ir),
    .mdr       (mdr),
    .mem_err   (mem_err),
    .ext       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access as control would issue it: command held until stall drops.
  // Memory acks in the lat-th REQ cycle; spurious acks are thrown in outside REQ.
  task automatic do_access(input logic iw, input logic mr, input logic mw, input logic iod,
                           input logic [31:0] pcv, input logic [31:0] av,
                           input logic [31:0] wd, input logic [31:0] rd, input int lat_in);
    int          lat;
    int          stall_cyc;
    int          req_cyc;
    int          cyc;
    bit          done;
    logic [31:0] e_addr;
    lat       = (lat_in > MAX_LAT) ? MAX_LAT : lat_in;
    e_addr    = iod ? av : pcv;
    stall_cyc = 0;
    req_cyc   = 0;
    cyc       = 0;
    done      = 0;
    @(negedge clk);
    ir_write  = iw;
    mem_read  = mr;
    mem_write = mw;
    i_or_d    = iod;
    pc        = pcv;
    alu_out   = av;
    wr_data   = wd;
    while (!done && cyc < 64) begin
      if (bus.ext_req) begin
        req_cyc++;
        check("addr_hold", bus.ext_addr, e_addr);
        check("we_hold", 32'(bus.ext_we), 32'(mw));
        check("wdata_hold", bus.ext_wdata, wd);
        bus.ext_ack   = (req_cyc == lat);
        bus.ext_rdata = (req_cyc == lat) ? rd : $urandom;
      end else begin
        bus.ext_ack   = 1'($urandom_range(0, 1));
        bus.ext_rdata = $urandom;
      end
      #1;
      if (stall) begin
        stall_cyc++;
      end else begin
        done = 1;
        check("done_req_low", 32'(bus.ext_req), 32'd0);
      end
      cyc++;
      if (!done) begin
        @(negedge clk);
        pc      = $urandom;
        alu_out = $urandom;
      end
    end
    @(negedge clk);
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    bus.ext_ack = 1'b0;
    if (!mw) begin
      if (iw) m_ir = rd;
      else    m_mdr = rd;
    end
    check("acc_completed", 32'(done), 32'd1);
    check("stall_cycles", 32'(stall_cyc), 32'(lat + 1));
    check("req_cycles", 32'(req_cyc), 32'(lat));
    check("ir", ir, m_ir);
    check("mdr", mdr, m_mdr);
    check("mem_err_low", 32'(mem_err), 32'd0);
  endtask

  initial begin
    int          rc;
    logic        r_iw;
    logic        r_mr;
    logic        r_mw;
    logic [2:0]  cmd;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req", 32'(bus.ext_req), 32'd0);
    check("rst_we", 32'(bus.ext_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_addr", bus.ext_addr, 32'd0);
    check("rst_wdata", bus.ext_wdata, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_mdr", mdr, 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);

    do_access(1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h8C220004, 1);
    do_access(0, 1, 0, 1, 32'h44, 32'h100, 32'h0, 32'h12345678, 5);
    do_access(0, 0, 1, 1, 32'h48, 32'h200, 32'hDEADBEEF, 32'hFFFF0000, 3);
    do_access(1, 0, 1, 1, 32'h4C, 32'h300, 32'hCAFEF00D, 32'h55AA55AA, 2);
    do_access(1, 1, 0, 0, 32'h50, 32'h400, 32'h0, 32'hA5A5A5A5, 1);
    do_access(0, 1, 1, 1, 32'h54, 32'h500, 32'h0BADF00D, 32'h77777777, 1);

    for (int i = 0; i < 40; i++) begin
      cmd = 3'($urandom_range(1, 7));
      r_iw = cmd[0];
      r_mr = cmd[1];
      r_mw = cmd[2];
      do_access(r_iw, r_mr, r_mw, 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom, $urandom, $urandom_range(1, MAX_LAT));
    end

    // reset during the second REQ cycle, then a late ack
    @(negedge clk);
    mem_read = 1'b1;
    i_or_d   = 1'b0;
    pc       = 32'h80;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_req_before", 32'(bus.ext_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    mem_read      = 1'b0;
    bus.ext_ack   = 1'b1;
    bus.ext_rdata = 32'hFEEDFACE;
    m_ir          = '0;
    m_mdr         = '0;
    #1;
    check("abort_req_low", 32'(bus.ext_req), 32'd0);
    check("abort_stall_low", 32'(stall), 32'd0);
    check("abort_ir", ir, m_ir);
    check("abort_addr", bus.ext_addr, 32'd0);
    @(negedge clk);
    bus.ext_ack = 1'b0;
    #1;
    check("late_ack_req", 32'(bus.ext_req), 32'd0);
    check("late_ack_ir", ir, m_ir);
    check("late_ack_mdr", mdr, m_mdr);
    do_access(1, 0, 0, 0, 32'h84, 32'h0, 32'h0, 32'h13572468, 2);

`ifdef MEM_TIMEOUT_EN
    do_access(0, 1, 0, 1, 32'h0, 32'h600, 32'h0, 32'h24681357, 4);
    @(negedge clk);
    mem_read    = 1'b1;
    i_or_d      = 1'b1;
    alu_out     = 32'h700;
    bus.ext_ack = 1'b0;
    rc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.ext_req) rc++;
    end
    mem_read = 1'b0;
    #1;
    check("to_req_cycles", 32'(rc), 32'd4);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_stall", 32'(stall), 32'd1);
    check("to_req_low", 32'(bus.ext_req), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("to_err_held", 32'(mem_err), 32'd1);
    check("to_stall_held", 32'(stall), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("to_err_cleared", 32'(mem_err), 32'd0);
    check("to_stall_cleared", 32'(stall), 32'd0);
`else
    rc = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
